vga_frame_capture: RTL and testbench

// - Receive end of the VGA link: decodes hsync/vsync/RGB (640x480@60, 25 MHz) back into framebuffer writes.
// - Tracks sync timing, declares lock, and on request captures one 320x240 2-bit frame from the top-left of the active area.
// - Writes follow the same 1:1 window and raster address order the display side reads.
// - Used for loopback self-test of the display path and for frame grabbing.

---
 rtl/vga_timing_pkg.sv | 14 +
 rtl/vga_frame_capture_if.sv | 8 +
 rtl/vga_timing_tracker.sv | 84 ++++++++
 rtl/vga_frame_capture.sv | 88 ++++++++
 tb/tb_vga_frame_capture.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and capture FSM encoding shared by the VGA blocks
package vga_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_BP = 48;
  localparam int H_TOTAL = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_BP = 33;
  localparam int V_TOTAL = 525;
  localparam int FB_WIDTH = 320;
  localparam int FB_HEIGHT = 240;
  localparam int LOCK_FRAMES = 2;
  localparam int FB_AW = 17;
  typedef enum logic [1:0] {CAP_IDLE, CAP_ARMED, CAP_CAPTURE} cap_state_t;
endpackage

// File: rtl/vga_frame_capture_if.sv
// vga_frame_capture_if: framebuffer write bus driven by the capture block
interface vga_frame_capture_if;
  logic wr_en;
  logic [16:0] wr_addr;
  logic [1:0] wr_data;
  modport master (output wr_en, wr_addr, wr_data);
  modport slave (input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vga_timing_tracker.sv
// vga_timing_tracker: registers the VGA inputs, follows raster position, validates sync periods and declares lock
module vga_timing_tracker #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_BP = vga_timing_pkg::H_BP,
  parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_BP = vga_timing_pkg::V_BP,
  parameter int V_TOTAL = vga_timing_pkg::V_TOTAL,
  parameter int FB_WIDTH = vga_timing_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = vga_timing_pkg::FB_HEIGHT,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input logic vga_clk_25,
  input logic reset_n,
  input logic hsync,
  input logic vsync,
  input logic [1:0] R,
  input logic [1:0] G,
  input logic [1:0] B,
  input logic capture_req,
  output logic [1:0] g_q,
  output logic req_q,
  output logic vs_rise,
  output logic pix_valid,
  output logic locked,
  output logic sync_error
);
  localparam logic [10:0] HT1 = 11'(H_TOTAL - 1);
  localparam logic [11:0] VT = 12'(V_TOTAL);
  localparam logic [10:0] HX0 = 11'(H_BP);
  localparam logic [10:0] HX1 = 11'(H_BP + (FB_WIDTH < H_ACTIVE ? FB_WIDTH : H_ACTIVE));
  localparam logic [10:0] VY0 = 11'(V_BP);
  localparam logic [10:0] VY1 = 11'(V_BP + (FB_HEIGHT < V_ACTIVE ? FB_HEIGHT : V_ACTIVE));
  localparam logic [3:0] LF = 4'(LOCK_FRAMES);
  logic hs_q, vs_q, hs_d, vs_d, hs_rise, h_seen, v_seen, h_bad, v_bad, rb_unused;
  logic [10:0] h_pos, v_line;
  logic [3:0] good;
  assign rb_unused = ^{R, B};
  assign hs_rise = hs_q & ~hs_d;
  assign vs_rise = vs_q & ~vs_d;
  assign h_bad = hs_rise && h_seen && h_pos != HT1;
  assign v_bad = vs_rise && v_seen && ({1'b0, v_line} + 12'(hs_rise)) != VT;
  assign pix_valid = h_pos >= HX0 && h_pos < HX1 && v_line >= VY0 && v_line < VY1;
  // input stage plus delayed sync copies; syncs idle high so reset leaves no false edge
  always_ff @(posedge vga_clk_25)
    if (!reset_n) begin
      {hs_q, vs_q, hs_d, vs_d} <= '1;
      g_q <= '0;
      req_q <= 1'b0;
    end else begin
      {hs_q, vs_q, hs_d, vs_d} <= {hsync, vsync, hs_q, vs_q};
      g_q <= G;
      req_q <= capture_req;
    end
  // saturating raster counters; a coincident vsync edge swallows the hsync increment
  always_ff @(posedge vga_clk_25)
    if (!reset_n) begin
      h_pos <= '0;
      v_line <= '0;
    end else begin
      h_pos <= hs_rise ? '0 : (h_pos == '1 ? h_pos : h_pos + 11'd1);
      v_line <= vs_rise ? '0 : (hs_rise && v_line != '1) ? v_line + 11'd1 : v_line;
    end
  // period checks and good-frame lock tracking; the first edge of each sync is unchecked
  always_ff @(posedge vga_clk_25)
    if (!reset_n) begin
      h_seen <= 1'b0;
      v_seen <= 1'b0;
      good <= '0;
      locked <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      h_seen <= h_seen | hs_rise;
      v_seen <= v_seen | vs_rise;
      sync_error <= h_bad | v_bad;
      if (h_bad || v_bad) begin
        good <= '0;
        locked <= 1'b0;
      end else if (vs_rise && v_seen) begin
        good <= good == LF ? good : good + 4'd1;
        locked <= locked | (good + 4'd1 == LF);
      end
    end
endmodule

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: grabs one FB_WIDTH x FB_HEIGHT frame of G from a locked VGA stream into framebuffer writes
module vga_frame_capture import vga_timing_pkg::*; #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_BP = vga_timing_pkg::H_BP,
  parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_BP = vga_timing_pkg::V_BP,
  parameter int V_TOTAL = vga_timing_pkg::V_TOTAL,
  parameter int FB_WIDTH = vga_timing_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = vga_timing_pkg::FB_HEIGHT,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input logic vga_clk_25,
  input logic reset_n,
  input logic hsync,
  input logic vsync,
  input logic [1:0] R,
  input logic [1:0] G,
  input logic [1:0] B,
  input logic capture_req,
  vga_frame_capture_if.master fb,
  output logic busy,
  output logic frame_done,
  output logic locked,
  output logic sync_error
);
  localparam logic [16:0] LAST = 17'(FB_WIDTH * FB_HEIGHT - 1);
  cap_state_t state;
  logic [1:0] g_q;
  logic req_q, vs_rise, pix_valid, done_pend;
  logic [16:0] wr_cnt;
  vga_timing_tracker #(
    .H_ACTIVE(H_ACTIVE), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
    .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .LOCK_FRAMES(LOCK_FRAMES)
  ) u_tracker (
    .vga_clk_25(vga_clk_25), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .R(R), .G(G), .B(B), .capture_req(capture_req),
    .g_q(g_q), .req_q(req_q), .vs_rise(vs_rise), .pix_valid(pix_valid),
    .locked(locked), .sync_error(sync_error)
  );
  // capture FSM: arm on request, start at the next frame, write the window in raster order
  always_ff @(posedge vga_clk_25)
    if (!reset_n) begin
      state <= CAP_IDLE;
      busy <= 1'b0;
      frame_done <= 1'b0;
      done_pend <= 1'b0;
      wr_cnt <= '0;
      fb.wr_en <= 1'b0;
      fb.wr_addr <= '0;
      fb.wr_data <= '0;
    end else begin
      frame_done <= done_pend;
      done_pend <= 1'b0;
      fb.wr_en <= 1'b0;
      fb.wr_data <= '0;
      if (done_pend) busy <= 1'b0;
      case (state)
        CAP_IDLE: if (req_q && locked && !busy) begin
          state <= CAP_ARMED;
          busy <= 1'b1;
        end
        CAP_ARMED: if (!locked) begin
          state <= CAP_IDLE;
          busy <= 1'b0;
        end else if (vs_rise) begin
          state <= CAP_CAPTURE;
          wr_cnt <= '0;
          fb.wr_addr <= '0;
        end
        CAP_CAPTURE: if (!locked) begin
          state <= CAP_IDLE;
          busy <= 1'b0;
        end else if (pix_valid) begin
          fb.wr_en <= 1'b1;
          fb.wr_data <= g_q;
          fb.wr_addr <= wr_cnt;
          wr_cnt <= wr_cnt + 17'd1;
          if (wr_cnt == LAST) begin
            state <= CAP_IDLE;
            done_pend <= 1'b1;
          end
        end
        default: state <= CAP_IDLE;
      endcase
    end
endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: directed raster stimulus on reduced timing with a write scoreboard
module tb_vga_frame_capture;
  localparam int HA = 16, HB = 4, HT = 28, VA = 12, VB = 3, VT = 18, FW = 8, FH = 6;
  localparam logic [16:0] LAST = 17'(FW * FH - 1);
  logic vga_clk_25 = 1'b0, reset_n, hsync, vsync, capture_req;
  logic [1:0] R, G, B;
  logic busy, frame_done, locked, sync_error;
  logic mon_en = 1'b0, nxt_done = 1'b0;
  logic [16:0] exp_addr = '0;
  logic [18:0] q[$];
  logic [18:0] ent;
  int cmp = 0, errs = 0, done_cnt = 0, se_cnt = 0;
  vga_frame_capture_if fb();
  vga_frame_capture #(
    .H_ACTIVE(HA), .H_BP(HB), .H_TOTAL(HT), .V_ACTIVE(VA), .V_BP(VB), .V_TOTAL(VT),
    .FB_WIDTH(FW), .FB_HEIGHT(FH), .LOCK_FRAMES(2)
  ) dut (
    .vga_clk_25(vga_clk_25), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .R(R), .G(G), .B(B), .capture_req(capture_req), .fb(fb),
    .busy(busy), .frame_done(frame_done), .locked(locked), .sync_error(sync_error)
  );
  always #20 vga_clk_25 = ~vga_clk_25;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge vga_clk_25)
    if (mon_en) begin
      check("frame_done", frame_done, nxt_done);
      nxt_done = 1'b0;
      if (fb.wr_en) begin
        check("wr_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          ent = q.pop_front();
          check("wr_addr", fb.wr_addr, ent[18:2]);
          check("wr_data", fb.wr_data, ent[1:0]);
          nxt_done = ent[18:2] == LAST;
        end
      end else check("idle_data", fb.wr_data, 0);
      if (frame_done) done_cnt++;
      if (sync_error) se_cnt++;
    end
  task automatic drive_lines(input int l0, input int l1, input bit cap, input int req_l,
                             input int short_l, input int stop_l, input int rst_l);
    for (int l = l0; l < l1; l++) begin
      int len;
      len = (l == short_l) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        int x, y;
        @(negedge vga_clk_25);
        if (l == rst_l && c == 25) check("busy_pre_rst", busy, 1);
        if (l == rst_l && c == 26) begin
          check("rst_wr_en", fb.wr_en, 0);
          check("rst_wr_addr", fb.wr_addr, 0);
          check("rst_busy", busy, 0);
          check("rst_locked", locked, 0);
          check("rst_done", frame_done, 0);
          check("rst_q_empty", q.size(), 0);
        end
        x = c - 1 - HB;
        y = l - VB;
        hsync = c < len - 4;
        vsync = l < VT - 2;
        G = 2'(x ^ y);
        R = 2'($urandom_range(0, 3));
        B = 2'($urandom_range(0, 3));
        reset_n = !(l == rst_l && c == 25);
        capture_req = l == req_l && c == 0;
        if (cap && (stop_l < 0 || l <= stop_l) && x >= 0 && x < FW && y >= 0 && y < FH) begin
          q.push_back({exp_addr, G});
          exp_addr++;
        end
      end
    end
  endtask
  initial begin
    reset_n = 1'b0; hsync = 1'b1; vsync = 1'b1; R = '0; G = '0; B = '0; capture_req = 1'b0;
    repeat (4) @(negedge vga_clk_25);
    reset_n = 1'b1;
    @(negedge vga_clk_25);
    mon_en = 1'b1;
    repeat (10) @(negedge vga_clk_25);
    check("reset_wr_en", fb.wr_en, 0);
    check("reset_wr_addr", fb.wr_addr, 0);
    check("reset_wr_data", fb.wr_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", frame_done, 0);
    check("reset_locked", locked, 0);
    check("reset_sync_error", sync_error, 0);
    capture_req = 1'b1;
    @(negedge vga_clk_25);
    capture_req = 1'b0;
    repeat (5) @(negedge vga_clk_25);
    check("busy_unlocked", busy, 0);
    for (int f = 0; f < 3; f++) drive_lines(0, VT, 0, -1, -1, -1, -1);
    check("locked_before", locked, 0);
    drive_lines(0, 2, 0, -1, -1, -1, -1);
    check("locked_rise", locked, 1);
    check("no_sync_error", se_cnt, 0);
    drive_lines(2, 3, 0, 2, -1, -1, -1);
    check("busy_armed", busy, 1);
    drive_lines(3, VT, 0, -1, -1, -1, -1);
    exp_addr = '0;
    drive_lines(0, VT, 1, 4, -1, -1, -1);
    check("cap1_done", done_cnt, 1);
    check("cap1_busy", busy, 0);
    check("cap1_q_empty", q.size(), 0);
    drive_lines(0, VT, 0, 2, -1, -1, -1);
    exp_addr = '0;
    drive_lines(0, VT, 1, -1, -1, -1, -1);
    check("cap2_done", done_cnt, 2);
    check("cap2_busy", busy, 0);
    check("cap2_q_empty", q.size(), 0);
    check("addr_hold", fb.wr_addr, LAST);
    drive_lines(0, VT, 0, 2, -1, -1, -1);
    exp_addr = '0;
    drive_lines(0, VT, 1, -1, 6, 6, -1);
    check("short_sync_error", se_cnt, 1);
    check("short_locked", locked, 0);
    check("short_busy", busy, 0);
    check("short_no_done", done_cnt, 2);
    check("short_q_empty", q.size(), 0);
    drive_lines(0, VT, 0, -1, -1, -1, -1);
    check("relock_one", locked, 0);
    drive_lines(0, 2, 0, -1, -1, -1, -1);
    check("relock_two", locked, 1);
    drive_lines(2, VT, 0, 2, -1, -1, -1);
    exp_addr = '0;
    drive_lines(0, VT, 1, -1, -1, 6, 6);
    check("rst_no_done", done_cnt, 2);
    check("rst_busy_after", busy, 0);
    drive_lines(0, VT, 0, -1, -1, -1, -1);
    drive_lines(0, VT, 0, -1, -1, -1, -1);
    check("postrst_one", locked, 0);
    drive_lines(0, 2, 0, -1, -1, -1, -1);
    check("postrst_two", locked, 1);
    check("final_sync_error", se_cnt, 1);
    check("final_q_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
